// File: rtl/adder_multiplier_32b.sv
// adder_multiplier_32b
//   Shared arithmetic core for the Mini-SRC ALU: a 32-bit carry-lookahead adder and a
//   32x32 signed radix-4 Booth multiplier. Both are combinational ahead of a single
//   registered output stage, so every accepted operation has a latency of one cycle.
//   Subtract, negate and increment are built by the caller through operand inversion
//   and carry-in.
//
// Ports
//   clk        in   1   clock, all state on rising edge
//   reset      in   1   synchronous active-high reset, takes priority over in_valid
//   in_valid   in   1   operands/op valid, captured on the clock edge
//   op         in   1   0 = add, 1 = signed multiply
//   x          in   32  adder operand A / multiplicand
//   y          in   32  adder operand B / multiplier
//   cin        in   1   adder carry-in, ignored for multiply
//   out_valid  out  1   in_valid delayed by one cycle
//   result     out  64  add: {32'b0, sum}; mul: signed 64-bit product
//   cout       out  1   adder carry-out, 0 for multiply
//   ovf        out  1   signed add overflow, 0 for multiply (only with ADD_OVF_EN)
//
// Configuration
//   ADD_OVF_EN  when defined, adds the ovf port and its signed-overflow logic.

module adder_multiplier_32b (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        op,
  input  logic [31:0] x,
  input  logic [31:0] y,
  input  logic        cin,
  output logic        out_valid,
  output logic [63:0] result,
  output logic        cout
`ifdef ADD_OVF_EN
  ,
  output logic        ovf
`endif
);

  // ---------------------------------------------------------------------------
  // Carry-lookahead adder: 8 blocks of 4 bits, block carries from group G/P
  // ---------------------------------------------------------------------------
  logic [31:0] bit_g, bit_p, sum;
  logic [7:0]  grp_g, grp_p;
  logic [7:0]  blk_cin;
  logic        add_cout;
  logic        lookahead_c;
  logic        ripple_c;

  always_comb begin
    bit_g = x & y;
    bit_p = x ^ y;

    for (int k = 0; k < 8; k++) begin
      grp_p[k] = &bit_p[4*k +: 4];
      grp_g[k] = bit_g[4*k+3]
               | (bit_p[4*k+3] & bit_g[4*k+2])
               | (bit_p[4*k+3] & bit_p[4*k+2] & bit_g[4*k+1])
               | (bit_p[4*k+3] & bit_p[4*k+2] & bit_p[4*k+1] & bit_g[4*k]);
    end

    // Block-level lookahead: each block's carry-in depends only on group terms.
    lookahead_c = cin;
    for (int k = 0; k < 8; k++) begin
      blk_cin[k]  = lookahead_c;
      lookahead_c = grp_g[k] | (grp_p[k] & lookahead_c);
    end
    add_cout = lookahead_c;

    // Bit carries inside each block start from that block's lookahead carry.
    sum = '0;
    for (int k = 0; k < 8; k++) begin
      ripple_c = blk_cin[k];
      for (int i = 0; i < 4; i++) begin
        sum[4*k+i] = bit_p[4*k+i] ^ ripple_c;
        ripple_c   = bit_g[4*k+i] | (bit_p[4*k+i] & ripple_c);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Radix-4 Booth multiplier: 16 sign-extended partial products
  // ---------------------------------------------------------------------------
  logic [32:0] y_ext;
  logic [63:0] mcand;
  logic [63:0] pp;
  logic [63:0] prod;

  always_comb begin
    y_ext = {y, 1'b0};  // implicit y[-1] = 0
    mcand = {{32{x[31]}}, x};
    pp    = '0;
    prod  = '0;
    for (int j = 0; j < 16; j++) begin
      case (y_ext[2*j +: 3])
        3'b001, 3'b010: pp = mcand;
        3'b011:         pp = mcand << 1;
        3'b100:         pp = -(mcand << 1);
        3'b101, 3'b110: pp = -mcand;
        default:        pp = '0;
      endcase
      prod = prod + (pp << (2 * j));
    end
  end

  // ---------------------------------------------------------------------------
  // Output select and register stage
  // ---------------------------------------------------------------------------
  logic [63:0] result_d;
  logic        cout_d;

  always_comb begin
    result_d = op ? prod : {32'b0, sum};
    cout_d   = op ? 1'b0 : add_cout;
  end

`ifdef ADD_OVF_EN
  logic ovf_d;

  always_comb begin
    ovf_d = ~op & (x[31] == y[31]) & (sum[31] != x[31]);
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      cout      <= 1'b0;
`ifdef ADD_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        result <= result_d;
        cout   <= cout_d;
`ifdef ADD_OVF_EN
        ovf    <= ovf_d;
`endif
      end
    end
  end

endmodule

// File: tb/tb_adder_multiplier_32b.sv
// Testbench for adder_multiplier_32b: directed vectors with hand-computed expectations
// pushed into a scoreboard queue; an independent monitor pops and compares on out_valid.

module tb_adder_multiplier_32b;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        op;
  logic [31:0] x;
  logic [31:0] y;
  logic        cin;
  logic        out_valid;
  logic [63:0] result;
  logic        cout;
`ifdef ADD_OVF_EN
  logic        ovf;
`endif

  adder_multiplier_32b dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .op        (op),
    .x         (x),
    .y         (y),
    .cin       (cin),
    .out_valid (out_valid),
    .result    (result),
    .cout      (cout)
`ifdef ADD_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  typedef struct packed {
    logic [63:0] res;
    logic        c;
    logic        o;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Drive one operation on the falling edge and record what should come back.
  task automatic issue(input logic o, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic [63:0] er, input logic ec,
                       input logic eo);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    op       = o;
    x        = a;
    y        = b;
    cin      = ci;
    e.res    = er;
    e.c      = ec;
    e.o      = eo;
    exp_q.push_back(e);
  endtask

  // Monitor: compare every presented result against the oldest expectation.
  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out_valid: got result %h with no pending expectation", result);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("result", result, e.res);
        check("cout", {63'b0, cout}, {63'b0, e.c});
`ifdef ADD_OVF_EN
        check("ovf", {63'b0, ovf}, {63'b0, e.o});
`endif
      end
    end
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    op       = 1'b0;
    x        = '0;
    y        = '0;
    cin      = 1'b0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset_result", result, 64'h0);
    check("reset_out_valid", {63'b0, out_valid}, 64'h0);
    check("reset_cout", {63'b0, cout}, 64'h0);
`ifdef ADD_OVF_EN
    check("reset_ovf", {63'b0, ovf}, 64'h0);
`endif
    reset = 1'b0;

    // Back-to-back stream: op, x, y, cin, result, cout, ovf
    issue(1'b0, 32'd10,        32'd5,         1'b0, 64'h0000_0000_0000_000F, 1'b0, 1'b0);
    issue(1'b0, 32'd15,        32'hFFFF_FFFA, 1'b1, 64'h0000_0000_0000_000A, 1'b1, 1'b0);
    issue(1'b0, 32'd0,         32'hFFFF_FFF8, 1'b1, 64'h0000_0000_FFFF_FFF9, 1'b0, 1'b0);
    issue(1'b0, 32'hFFFF_FFFF, 32'd1,         1'b0, 64'h0000_0000_0000_0000, 1'b1, 1'b0);
    issue(1'b0, 32'h7FFF_FFFF, 32'd1,         1'b0, 64'h0000_0000_8000_0000, 1'b0, 1'b1);
    issue(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 64'h0000_0000_0000_0000, 1'b1, 1'b1);
    issue(1'b1, 32'd4,         32'd3,         1'b0, 64'h0000_0000_0000_000C, 1'b0, 1'b0);
    issue(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'h0000_0000_0000_0001, 1'b0, 1'b0);
    issue(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0, 64'h4000_0000_0000_0000, 1'b0, 1'b0);
    issue(1'b1, 32'hFFFF_FFF9, 32'd3,         1'b0, 64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 1'b0);
    issue(1'b1, 32'h1234_5678, 32'd0,         1'b0, 64'h0000_0000_0000_0000, 1'b0, 1'b0);
    issue(1'b1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0, 64'h3FFF_FFFF_0000_0001, 1'b0, 1'b0);
    issue(1'b1, 32'h8000_0000, 32'd1,         1'b0, 64'hFFFF_FFFF_8000_0000, 1'b0, 1'b0);
    issue(1'b1, 32'd5,         32'd6,         1'b1, 64'h0000_0000_0000_001E, 1'b0, 1'b0);
    issue(1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0, 64'h0000_0000_2345_6789, 1'b0, 1'b0);

    // Hold: pulse then idle with new operands; outputs keep the last result
    issue(1'b0, 32'd10, 32'd5, 1'b0, 64'h0000_0000_0000_000F, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    op       = 1'b1;
    x        = 32'd99;
    y        = 32'd7;
    cin      = 1'b1;
    @(negedge clk);
    check("hold_out_valid", {63'b0, out_valid}, 64'h0);
    check("hold_result", result, 64'h0000_0000_0000_000F);
    check("hold_cout", {63'b0, cout}, 64'h0);

    // Reset beats in_valid, discarding the captured op
    issue(1'b0, 32'd1, 32'd2, 1'b0, 64'h0000_0000_0000_0003, 1'b0, 1'b0);
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b1;
    op       = 1'b1;
    x        = 32'd4;
    y        = 32'd3;
    cin      = 1'b0;
    @(negedge clk);
    check("rst_mid_out_valid", {63'b0, out_valid}, 64'h0);
    check("rst_mid_result", result, 64'h0);
    check("rst_mid_cout", {63'b0, cout}, 64'h0);
    reset = 1'b0;
    in_valid = 1'b0;

    // First post-reset operation is fresh
    issue(1'b1, 32'd7, 32'd6, 1'b0, 64'h0000_0000_0000_002A, 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending results want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
